// File: rtl/if_id_queue_if.sv
//==============================================================================
// Module      : if_id_queue_if
// Description : Fetch/decode handshake bundle for the IF/ID decoupling queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface if_id_queue_if #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
);
  logic                     if_valid;
  logic                     if_ready;
  logic [WORD_SIZE-1:0]     if_pc;
  logic [WORD_SIZE-1:0]     if_instruction;
  logic                     flush;
  logic                     id_stall;
  logic                     id_valid;
  logic [WORD_SIZE-1:0]     id_pc;
  logic [WORD_SIZE-1:0]     id_instruction;
  logic [$clog2(DEPTH):0]   count;

  // Driven by fetch/decode control.
  modport master (
    output if_valid, if_pc, if_instruction, flush, id_stall,
    input  if_ready, id_valid, id_pc, id_instruction, count
  );

  // The queue itself.
  modport slave (
    input  if_valid, if_pc, if_instruction, flush, id_stall,
    output if_ready, id_valid, id_pc, id_instruction, count
  );
endinterface

`default_nettype wire

// File: rtl/if_id_queue.sv
//==============================================================================
// Module      : if_id_queue
// Description : In-order {PC, instruction} FIFO between fetch and decode with
//               show-ahead head, decode stall and branch flush.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_queue #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] NOP       = '0
) (
  input  wire               clk,
  input  wire               rst,
  if_id_queue_if.slave      bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WORD_SIZE-1:0] r_pcMem    [DEPTH];
  logic [WORD_SIZE-1:0] r_instrMem [DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [c_CNT_W-1:0]   r_count;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // No full-bypass: a pop in the full cycle does not open the input.
  assign w_ready = rst & (r_count != c_FULL);
  assign w_valid = rst & (r_count != '0);
  assign w_push  = bus.if_valid & w_ready;
  assign w_pop   = w_valid & ~bus.id_stall;

  assign bus.if_ready       = w_ready;
  assign bus.id_valid       = w_valid;
  assign bus.id_pc          = w_valid ? r_pcMem[r_rdPtr]    : '0;
  assign bus.id_instruction = w_valid ? r_instrMem[r_rdPtr] : NOP;
  assign bus.count          = r_count;

  // Reset and flush share one path: both discard everything in flight.
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage is never cleared; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) begin
      r_pcMem[r_wrPtr]    <= bus.if_pc;
      r_instrMem[r_wrPtr] <= bus.if_instruction;
    end
  end

endmodule

`default_nettype wire
